// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: one full_subtractor cell walks the operands LSB first,
// recirculating its borrow through a flop, and reports the result with a done pulse.

module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic d,
  output logic bor
);
  assign d   = a ^ b ^ c;
  assign bor = (~a & b) | (~(a ^ b) & c);
endmodule

module serial_subtractor_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  localparam int unsigned   CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa, sb, sr, sr_next;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             cell_d, cell_bor;
  logic             busy_d, done_d, last_bit;

  full_subtractor u_cell (
    .a  (sa[0]),
    .b  (sb[0]),
    .c  (br),
    .d  (cell_d),
    .bor(cell_bor)
  );

  // New difference bit enters at the MSB; also covers WIDTH == 1.
  assign sr_next  = WIDTH'({cell_d, sr} >> 1);
  assign last_bit = (cnt == LAST);

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
      sa      <= '0;
      sb      <= '0;
      sr      <= '0;
      br      <= 1'b0;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            sa  <= in_a;
            sb  <= in_b;
            br  <= bin;
            cnt <= '0;
            sr  <= '0;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sr  <= sr_next;
          br  <= cell_bor;
          cnt <= cnt + CW'(1);
          // Result is published only on the final bit.
          if (last_bit) begin
            diff <= sr_next;
            bout <= cell_bor;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Scoreboard bench for serial_subtractor_ctrl at WIDTH=8 and WIDTH=1 against an
// arithmetic reference model of the subtract and its busy/done timing.

module tb_serial_subtractor_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       st8 = 1'b0, bi8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;
  logic       st1 = 1'b0, bi1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, bout1;
  logic [0:0] diff1;

  typedef struct {
    int unsigned diff;
    bit          bout;
    int          done_cyc;
  } exp_t;

  exp_t        q8[$], q1[$];
  int          cnt8 = 0, cnt1 = 0;
  int          cyc = 0;
  int          total = 0, bad = 0;
  int unsigned held_d8 = 0, held_d1 = 0;
  bit          held_b8 = 0, held_b1 = 0;
  bit          w1_fin = 0;

  serial_subtractor_ctrl #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(st8), .in_a(a8), .in_b(b8), .bin(bi8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor_ctrl #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .start(st1), .in_a(a1), .in_b(b1), .bin(bi1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  function automatic exp_t ref_sub(input int unsigned w, input int unsigned a,
                                   input int unsigned b, input int unsigned bi,
                                   input int c);
    exp_t   e;
    longint m = longint'(1) << w;
    longint r = longint'(a) - longint'(b) - longint'(bi);
    e.bout     = (r < 0);
    e.diff     = 32'((r + m) % m);
    e.done_cyc = c + int'(w);
    return e;
  endfunction

  // Reference model: accepts a start whenever the unit has been idle, busy WIDTH+1 cycles.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      cnt8 = 0;
      cnt1 = 0;
      q8.delete();
      q1.delete();
    end else begin
      if (cnt8 > 0) cnt8--;
      else if (st8) begin
        q8.push_back(ref_sub(8, a8, b8, bi8, cyc));
        cnt8 = 9;
      end
      if (cnt1 > 0) cnt1--;
      else if (st1) begin
        q1.push_back(ref_sub(1, a1, b1, bi1, cyc));
        cnt1 = 2;
      end
    end
  end

  // Monitor: pops a result whenever a done is presented, checks outputs every cycle.
  always @(posedge clk) begin
    bit   e8, e1;
    exp_t it;
    #2;
    if (rst) begin
      held_d8 = 0; held_b8 = 0;
      held_d1 = 0; held_b1 = 0;
    end
    e8 = (q8.size() > 0) && (q8[0].done_cyc == cyc);
    chk("w8_busy", busy8, cnt8 > 0);
    chk("w8_done", done8, e8);
    if ((done8 || e8) && q8.size() > 0) begin
      it = q8.pop_front();
      held_d8 = it.diff;
      held_b8 = it.bout;
    end
    chk("w8_diff", diff8, held_d8);
    chk("w8_bout", bout8, held_b8);

    e1 = (q1.size() > 0) && (q1[0].done_cyc == cyc);
    chk("w1_busy", busy1, cnt1 > 0);
    chk("w1_done", done1, e1);
    if ((done1 || e1) && q1.size() > 0) begin
      it = q1.pop_front();
      held_d1 = it.diff;
      held_b1 = it.bout;
    end
    chk("w1_diff", diff1, held_d1);
    chk("w1_bout", bout1, held_b1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One accepted op followed by scrambled inputs until the next issue slot.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit bi);
    a8 = a; b8 = b; bi8 = bi; st8 = 1'b1;
    tick(1);
    st8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
    tick(9);
  endtask

  initial begin
    st8 = 1'b1; st1 = 1'b1; a8 = 8'h5A; b8 = 8'h23;
    tick(2);
    rst = 1'b0; st8 = 1'b0; st1 = 1'b0;

    op8(8'h5A, 8'h23, 1'b0);
    op8(8'h10, 8'h20, 1'b0);
    op8(8'h00, 8'h00, 1'b1);
    op8(8'hFF, 8'hFF, 1'b0);
    op8(8'h80, 8'h7F, 1'b1);

    // Starts during RUN and during DONE must be ignored.
    a8 = 8'h5A; b8 = 8'h23; bi8 = 1'b0; st8 = 1'b1;
    tick(1);
    st8 = 1'b0;
    tick(2);
    a8 = 8'hFF; b8 = 8'h01; st8 = 1'b1;
    tick(1);
    st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    tick(5);
    a8 = 8'hFF; b8 = 8'h01; st8 = 1'b1;
    tick(1);
    st8 = 1'b0;
    tick(1);

    // Start held high with operands changing every cycle.
    st8 = 1'b1;
    repeat (35) begin
      a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
      tick(1);
    end
    st8 = 1'b0;
    tick(10);

    // Reset on the fourth edge of a run aborts it.
    a8 = 8'hC3; b8 = 8'h11; bi8 = 1'b1; st8 = 1'b1;
    tick(1);
    st8 = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    op8(8'h09, 8'h03, 1'b0);

    repeat (25) begin
      a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom); st8 = 1'b1;
      tick(1);
      st8 = 1'b0;
      tick(int'($urandom_range(0, 12)));
    end
    tick(12);

    for (int i = 0; i < 2000 && !w1_fin; i++) tick(1);
    chk("w1_finished", w1_fin, 1);
    chk("w8_pending", q8.size(), 0);
    chk("w1_pending", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    tick(3);
    for (int c = 0; c < 8; c++) begin
      a1 = 1'(c >> 2); b1 = 1'(c >> 1); bi1 = 1'(c); st1 = 1'b1;
      tick(1);
      st1 = 1'b0;
      tick(2);
    end
    repeat (60) begin
      a1 = 1'($urandom); b1 = 1'($urandom); bi1 = 1'($urandom); st1 = 1'b1;
      tick(1);
      st1 = 1'b0;
      tick(int'($urandom_range(0, 3)));
    end
    tick(4);
    w1_fin = 1'b1;
  end
endmodule
